// File: rtl/fp_result_queue.sv
// Writeback FIFO behind the fp multiplier: queues result/flags/mode entries,
// and keeps sticky exception flags, a saturating inexact counter and an irq.
module fp_result_queue #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_result,
  input  logic [4:0]                in_flags,
  input  logic                      in_mode_fp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_result,
  output logic [4:0]                out_flags,
  output logic                      out_mode_fp,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      flag_clr,
  input  logic [4:0]                flag_en,
  output logic [4:0]                acc_flags,
  output logic [15:0]               inexact_cnt,
  output logic                      irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [4:0] ACC_MASK = 5'b11101;

  logic [37:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic [4:0]    acc_q, acc_d;
  logic [15:0]   inexact_q, inexact_d;
  logic          irq_q, irq_d;
  logic          push, pop;
  logic [31:0]   store_result;
  logic [37:0]   head;

  assign in_ready  = !rst && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // fp16 results only carry meaningful data in the low half
  assign store_result = in_mode_fp ? in_result : {16'h0000, in_result[15:0]};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= {in_mode_fp, in_flags, store_result};
    end
  end

  assign head        = mem_q[rp_q];
  assign out_result  = out_valid ? head[31:0]  : 32'h0;
  assign out_flags   = out_valid ? head[36:32] : 5'h0;
  assign out_mode_fp = out_valid ? head[37]    : 1'b0;

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    acc_d     = acc_q;
    inexact_d = inexact_q;
    irq_d     = |(acc_q & flag_en);
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // a clear coinciding with a push keeps the new event
    if (flag_clr) begin
      acc_d = push ? (in_flags & ACC_MASK) : 5'h0;
    end else if (push) begin
      acc_d = acc_q | (in_flags & ACC_MASK);
    end
    if (push && in_flags[0] && (inexact_q != 16'hFFFF)) begin
      inexact_d = inexact_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      inexact_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      inexact_q <= inexact_d;
      irq_q     <= irq_d;
    end
  end

  assign count       = count_q;
  assign acc_flags   = acc_q;
  assign inexact_cnt = inexact_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_fp_result_queue.sv
// Scoreboard bench for fp_result_queue: driver updates a queue-level model,
// a negedge monitor compares every observable output against it.
module tb_fp_result_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_mode_fp, out_valid, out_ready;
  logic [31:0] in_result, out_result;
  logic [4:0]  in_flags, out_flags, flag_en, acc_flags;
  logic        out_mode_fp, flag_clr, irq;
  logic [2:0]  count;
  logic [15:0] inexact_cnt;

  always #5 clk = ~clk;

  fp_result_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_mode_fp(in_mode_fp),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_mode_fp(out_mode_fp), .count(count),
    .flag_clr(flag_clr), .flag_en(flag_en), .acc_flags(acc_flags),
    .inexact_cnt(inexact_cnt), .irq(irq)
  );

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    logic        m;
  } ent_t;

  ent_t        sb[$];
  int          occ_m;
  logic [4:0]  acc_m;
  logic [15:0] inx_m;
  logic        irq_m;
  bit          mon_en = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge and apply the queue-level rules to the model.
  task automatic step();
    bit   push, pop;
    ent_t e;
    @(posedge clk);
    push = !rst && in_valid && (occ_m < DEPTH);
    pop  = !rst && out_ready && (occ_m > 0);
    if (rst) begin
      occ_m = 0; acc_m = 0; inx_m = 0; irq_m = 0;
      sb.delete();
    end else begin
      irq_m = |(acc_m & flag_en);
      if (flag_clr) acc_m = push ? (in_flags & 5'b11101) : 5'b0;
      else if (push) acc_m = acc_m | (in_flags & 5'b11101);
      if (push && in_flags[0] && inx_m != 16'hFFFF) inx_m = inx_m + 16'd1;
      if (push) begin
        e.r = in_mode_fp ? in_result : {16'h0000, in_result[15:0]};
        e.f = in_flags;
        e.m = in_mode_fp;
        sb.push_back(e);
      end
      occ_m = occ_m + int'(push) - int'(pop);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] f,
                       input logic m, input logic ordy, input logic clr);
    in_valid = v; in_result = r; in_flags = f; in_mode_fp = m;
    out_ready = ordy; flag_clr = clr;
    step();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(occ_m));
      chk("in_ready", 32'(in_ready), 32'(!rst && occ_m != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(occ_m != 0));
      chk("acc_flags", 32'(acc_flags), 32'(acc_m));
      chk("inexact_cnt", 32'(inexact_cnt), 32'(inx_m));
      chk("irq", 32'(irq), 32'(irq_m));
      if (occ_m == 0) begin
        chk("idle_result", out_result, 32'h0);
        chk("idle_flags", 32'(out_flags), 32'h0);
        chk("idle_mode", 32'(out_mode_fp), 32'h0);
      end else if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: model holds %0d entries, none queued", occ_m);
      end else begin
        chk("out_result", out_result, sb[0].r);
        chk("out_flags", 32'(out_flags), 32'(sb[0].f));
        chk("out_mode_fp", 32'(out_mode_fp), 32'(sb[0].m));
        if (out_ready && !rst) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_result = 0; in_flags = 0; in_mode_fp = 0;
    out_ready = 0; flag_clr = 0; flag_en = 0;
    occ_m = 0; acc_m = 0; inx_m = 0; irq_m = 0;
    step();
    mon_en = 1;
    step();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);

    // single op, then idle
    drive(1, 32'h40C00000, 5'b0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    // fill to full, fifth push is dropped, then drain across wrap
    for (int i = 0; i < 5; i++) drive(1, 32'h3F800000 + 32'(i), 5'b0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0);

    // steady push+pop at count 2
    for (int i = 0; i < 2; i++) drive(1, 32'h41000000 + 32'(i), 5'b0, 1, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, 32'h42000000 + 32'(i), 5'b0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);

    // flag accumulation, irq, clear with a coincident push
    flag_en = 5'b01000;
    drive(1, 32'h3F000000, 5'b00001, 1, 1, 0);
    drive(1, 32'h3F000001, 5'b01000, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 32'h3F000002, 5'b10010, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0);

    // fp16 masking
    drive(1, 32'hDEAD3C00, 5'b0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);

    // reset mid-run with a push pending
    for (int i = 0; i < 3; i++) drive(1, 32'h50000000 + 32'(i), 5'b00001, 1, 0, 0);
    in_valid = 1; in_result = 32'h5000000A; rst = 1; out_ready = 1;
    step();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) flag_en = 5'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      drive(1'($urandom_range(0, 2) != 0), $urandom, 5'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0));
    end
    rst = 0;
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
